vga_output_stage: RTL and testbench

- Parametrised, registered successor to the combinational VGA pin adapter; sits between the timing/pixel generator and the board DAC pins.
- Widens colour from IN_BITS to OUT_BITS by bit replication and delays colour, sync and blank through a PIPE_DEPTH-stage pipeline so all outputs stay aligned.
- Adds runtime output modes (pass, grayscale, colour bars, solid colour) that switch only at frame boundaries, plus a frame counter.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_bar_gen.sv | 45 ++++
 rtl/vga_output_stage.sv | 149 ++++++++++++++
 tb/tb_vga_output_stage.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA output stage: mode encodings, bar count
// and the colour widening helper.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GRAY  = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_SOLID = 2'd3
    } vga_mode_e;

    localparam int BAR_COUNT    = 8;
    localparam int MAX_IN_BITS  = 8;
    localparam int MAX_OUT_BITS = 10;

    // Repeats the in_bits-wide value MSB-first until at least out_bits bits
    // exist, then keeps the top out_bits of that stream.
    function automatic logic [MAX_OUT_BITS-1:0] widen(
        input logic [MAX_IN_BITS-1:0] value,
        input int                     in_bits,
        input int                     out_bits
    );
        logic [19:0] acc;
        int          bits;
        acc  = '0;
        bits = 0;
        for (int k = 0; k < MAX_OUT_BITS; k++) begin
            if (bits < out_bits) begin
                acc  = (acc << in_bits) | 20'(value);
                bits = bits + in_bits;
            end
        end
        return MAX_OUT_BITS'(acc >> (bits - out_bits));
    endfunction

endpackage

// File: rtl/vga_bar_gen.sv
// Colour-bar source: eight equal-width bars across the active line,
// restarting from white at the start of every line.
module vga_bar_gen
    import vga_pkg::*;
#(
    parameter int IN_BITS  = 4,
    parameter int H_ACTIVE = 640
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               video_output,
    output logic [IN_BITS-1:0] bar_r,
    output logic [IN_BITS-1:0] bar_g,
    output logic [IN_BITS-1:0] bar_b
);

    localparam int COLS  = H_ACTIVE / BAR_COUNT;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [2:0]       IDX_LAST = 3'(BAR_COUNT - 1);

    logic [COL_W-1:0] col;
    logic [2:0]       idx;

    // The last bar holds until blanking clears both counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            idx <= '0;
        end else if (!video_output) begin
            col <= '0;
            idx <= '0;
        end else if (col == COL_LAST) begin
            col <= '0;
            if (idx != IDX_LAST) idx <= idx + 3'd1;
        end else begin
            col <= col + COL_W'(1);
        end
    end

    assign bar_r = {IN_BITS{~idx[1]}};
    assign bar_g = {IN_BITS{~idx[2]}};
    assign bar_b = {IN_BITS{~idx[0]}};

endmodule

// File: rtl/vga_output_stage.sv
// Registered VGA output stage: selects the colour source per frame-locked
// mode, widens to DAC width and delays colour/sync/blank with equal latency.
module vga_output_stage
    import vga_pkg::*;
#(
    parameter int IN_BITS         = 4,
    parameter int OUT_BITS        = 8,
    parameter int PIPE_DEPTH      = 2,
    parameter int H_ACTIVE        = 640,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IN_BITS-1:0]     r,
    input  logic [IN_BITS-1:0]     g,
    input  logic [IN_BITS-1:0]     b,
    input  logic                   horizontal_sync,
    input  logic                   vertical_sync,
    input  logic                   video_output,
    input  logic [1:0]             mode,
    input  logic [3*IN_BITS-1:0]   solid_rgb,
    output logic [OUT_BITS-1:0]    vga_r,
    output logic [OUT_BITS-1:0]    vga_g,
    output logic [OUT_BITS-1:0]    vga_b,
    output logic                   vga_horizontal_sync,
    output logic                   vga_vertical_sync,
    output logic                   vga_clk,
    output logic                   vga_blank_n,
    output logic                   vga_sync_n,
    output logic [15:0]            frame_count
);

    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

    logic              vs_prev;
    logic              frame_start;
    vga_mode_e         mode_active;
    vga_mode_e         mode_eff;
    logic [IN_BITS+1:0] luma_sum;
    logic [IN_BITS-1:0] gray;
    logic [IN_BITS-1:0] bar_r, bar_g, bar_b;
    logic [IN_BITS-1:0] sel_r, sel_g, sel_b;
    logic [OUT_BITS-1:0] wide_r, wide_g, wide_b;

    logic [PIPE_DEPTH-1:0][OUT_BITS-1:0] r_pipe, g_pipe, b_pipe;
    logic [PIPE_DEPTH-1:0]               hs_pipe, vs_pipe, blank_pipe;

    assign frame_start = (vs_prev == SYNC_IDLE) && (vertical_sync != SYNC_IDLE);
    // A mode presented together with the frame start governs that same pixel.
    assign mode_eff    = frame_start ? vga_mode_e'(mode) : mode_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev     <= SYNC_IDLE;
            mode_active <= MODE_PASS;
            frame_count <= '0;
        end else begin
            vs_prev <= vertical_sync;
            if (frame_start) begin
                mode_active <= vga_mode_e'(mode);
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    vga_bar_gen #(
        .IN_BITS  (IN_BITS),
        .H_ACTIVE (H_ACTIVE)
    ) u_bar_gen (
        .clk          (clk),
        .rst          (rst),
        .video_output (video_output),
        .bar_r        (bar_r),
        .bar_g        (bar_g),
        .bar_b        (bar_b)
    );

    assign luma_sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    assign gray     = IN_BITS'(luma_sum >> 2);

    always_comb begin
        sel_r = r;
        sel_g = g;
        sel_b = b;
        case (mode_eff)
            MODE_GRAY: begin
                sel_r = gray;
                sel_g = gray;
                sel_b = gray;
            end
            MODE_BARS: begin
                sel_r = bar_r;
                sel_g = bar_g;
                sel_b = bar_b;
            end
            MODE_SOLID: begin
                sel_r = solid_rgb[3*IN_BITS-1 -: IN_BITS];
                sel_g = solid_rgb[2*IN_BITS-1 -: IN_BITS];
                sel_b = solid_rgb[IN_BITS-1:0];
            end
            default: ;
        endcase
        if (!video_output) begin
            sel_r = '0;
            sel_g = '0;
            sel_b = '0;
        end
    end

    assign wide_r = OUT_BITS'(widen(MAX_IN_BITS'(sel_r), IN_BITS, OUT_BITS));
    assign wide_g = OUT_BITS'(widen(MAX_IN_BITS'(sel_g), IN_BITS, OUT_BITS));
    assign wide_b = OUT_BITS'(widen(MAX_IN_BITS'(sel_b), IN_BITS, OUT_BITS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe     <= '0;
            g_pipe     <= '0;
            b_pipe     <= '0;
            hs_pipe    <= {PIPE_DEPTH{SYNC_IDLE}};
            vs_pipe    <= {PIPE_DEPTH{SYNC_IDLE}};
            blank_pipe <= '0;
        end else begin
            r_pipe[0]     <= wide_r;
            g_pipe[0]     <= wide_g;
            b_pipe[0]     <= wide_b;
            hs_pipe[0]    <= horizontal_sync;
            vs_pipe[0]    <= vertical_sync;
            blank_pipe[0] <= video_output;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                r_pipe[s]     <= r_pipe[s-1];
                g_pipe[s]     <= g_pipe[s-1];
                b_pipe[s]     <= b_pipe[s-1];
                hs_pipe[s]    <= hs_pipe[s-1];
                vs_pipe[s]    <= vs_pipe[s-1];
                blank_pipe[s] <= blank_pipe[s-1];
            end
        end
    end

    assign vga_r               = r_pipe[PIPE_DEPTH-1];
    assign vga_g               = g_pipe[PIPE_DEPTH-1];
    assign vga_b               = b_pipe[PIPE_DEPTH-1];
    assign vga_horizontal_sync = hs_pipe[PIPE_DEPTH-1];
    assign vga_vertical_sync   = vs_pipe[PIPE_DEPTH-1];
    assign vga_blank_n         = blank_pipe[PIPE_DEPTH-1];
    assign vga_clk             = clk;
    assign vga_sync_n          = 1'b0;

endmodule

// File: tb/tb_vga_output_stage.sv
// Bench for vga_output_stage: two configurations driven from one video
// timeline, each checked every cycle against a behavioural pixel model.
module tb_vga_output_stage;

    localparam int INA = 4, OUTA = 8, DA = 2, HA = 640;
    localparam int INB = 5, OUTB = 8, DB = 4, HB = 64;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       hs;
        logic       vs;
        logic       bl;
    } exp_t;

    logic clk, rst;
    logic [INA-1:0] r_a, g_a, b_a;
    logic [INB-1:0] r_b, g_b, b_b;
    logic [3*INA-1:0] solid_a;
    logic [3*INB-1:0] solid_b;
    logic vid, hs_act, vs_act;
    logic [1:0] mode;
    logic hs_in_a, vs_in_a, hs_in_b, vs_in_b;

    logic [OUTA-1:0] vga_r_a, vga_g_a, vga_b_a;
    logic [OUTB-1:0] vga_r_b, vga_g_b, vga_b_b;
    logic hs_a, vs_a, clk_a, blank_a, syncn_a;
    logic hs_b, vs_b, clk_b, blank_b, syncn_b;
    logic [15:0] fc_a, fc_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Syncs active low on A, active high on B.
    assign hs_in_a = ~hs_act;
    assign vs_in_a = ~vs_act;
    assign hs_in_b = hs_act;
    assign vs_in_b = vs_act;

    vga_output_stage #(
        .IN_BITS(INA), .OUT_BITS(OUTA), .PIPE_DEPTH(DA), .H_ACTIVE(HA), .SYNC_ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .r(r_a), .g(g_a), .b(b_a),
        .horizontal_sync(hs_in_a), .vertical_sync(vs_in_a), .video_output(vid),
        .mode(mode), .solid_rgb(solid_a),
        .vga_r(vga_r_a), .vga_g(vga_g_a), .vga_b(vga_b_a),
        .vga_horizontal_sync(hs_a), .vga_vertical_sync(vs_a), .vga_clk(clk_a),
        .vga_blank_n(blank_a), .vga_sync_n(syncn_a), .frame_count(fc_a)
    );

    vga_output_stage #(
        .IN_BITS(INB), .OUT_BITS(OUTB), .PIPE_DEPTH(DB), .H_ACTIVE(HB), .SYNC_ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .r(r_b), .g(g_b), .b(b_b),
        .horizontal_sync(hs_in_b), .vertical_sync(vs_in_b), .video_output(vid),
        .mode(mode), .solid_rgb(solid_b),
        .vga_r(vga_r_b), .vga_g(vga_g_b), .vga_b(vga_b_b),
        .vga_horizontal_sync(hs_b), .vga_vertical_sync(vs_b), .vga_clk(clk_b),
        .vga_blank_n(blank_b), .vga_sync_n(syncn_b), .frame_count(fc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Output bit j (from MSB) is input bit (j mod inb) counted from MSB.
    function automatic logic [9:0] widen_m(int v, int inb, int outb);
        logic [9:0] w;
        w = '0;
        for (int j = 0; j < outb; j++)
            w[outb-1-j] = ((v >> (inb - 1 - (j % inb))) & 1) != 0;
        return w;
    endfunction

    function automatic logic [23:0] bar_rgb(int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // run = number of consecutive active pixels before this one.
    function automatic exp_t model_pixel(int inb, int outb, int h, int m, int r, int g, int b,
                                         int solid, bit v, int run, bit hs, bit vs);
        exp_t e;
        int full, cr, cg, cb, idx;
        logic [23:0] rgb;
        full = (1 << inb) - 1;
        cr = 0; cg = 0; cb = 0;
        if (v) begin
            case (m)
                0: begin cr = r; cg = g; cb = b; end
                1: begin cr = ((r + 2 * g + b) / 4) & full; cg = cr; cb = cr; end
                2: begin
                    idx = run / (h / 8);
                    if (idx > 7) idx = 7;
                    rgb = bar_rgb(idx);
                    cr = (rgb[23:16] != 0) ? full : 0;
                    cg = (rgb[15:8]  != 0) ? full : 0;
                    cb = (rgb[7:0]   != 0) ? full : 0;
                end
                default: begin
                    cr = (solid >> (2 * inb)) & full;
                    cg = (solid >> inb) & full;
                    cb = solid & full;
                end
            endcase
        end
        e.r = widen_m(cr, inb, outb);
        e.g = widen_m(cg, inb, outb);
        e.b = widen_m(cb, inb, outb);
        e.hs = hs; e.vs = vs; e.bl = v;
        return e;
    endfunction

    function automatic exp_t reset_entry(bit idle);
        exp_t e;
        e = '0;
        e.hs = idle;
        e.vs = idle;
        return e;
    endfunction

    exp_t qa[$], qb[$];
    exp_t exp_a, exp_b;
    int fca, fcb, ma, mb, runa, runb;
    bit vspa, vspb;
    bit ready_a = 0, ready_b = 0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            qa.delete();
            exp_a = reset_entry(1'b1);
            for (int i = 0; i < DA - 1; i++) qa.push_back(exp_a);
            fca = 0; ma = 0; runa = 0; vspa = 1'b1; ready_a = 1;
        end else begin : step_a
            bit fs;
            int meff;
            fs = (vspa == 1'b1) && (vs_in_a == 1'b0);
            meff = fs ? int'(mode) : ma;
            if (fs) begin ma = int'(mode); fca = (fca + 1) % 65536; end
            qa.push_back(model_pixel(INA, OUTA, HA, meff, int'(r_a), int'(g_a), int'(b_a),
                                     int'(solid_a), vid, runa, hs_in_a, vs_in_a));
            runa = vid ? runa + 1 : 0;
            vspa = vs_in_a;
            exp_a = qa.pop_front();
        end
    end

    initial forever begin
        @(posedge clk);
        if (rst) begin
            qb.delete();
            exp_b = reset_entry(1'b0);
            for (int i = 0; i < DB - 1; i++) qb.push_back(exp_b);
            fcb = 0; mb = 0; runb = 0; vspb = 1'b0; ready_b = 1;
        end else begin : step_b
            bit fs;
            int meff;
            fs = (vspb == 1'b0) && (vs_in_b == 1'b1);
            meff = fs ? int'(mode) : mb;
            if (fs) begin mb = int'(mode); fcb = (fcb + 1) % 65536; end
            qb.push_back(model_pixel(INB, OUTB, HB, meff, int'(r_b), int'(g_b), int'(b_b),
                                     int'(solid_b), vid, runb, hs_in_b, vs_in_b));
            runb = vid ? runb + 1 : 0;
            vspb = vs_in_b;
            exp_b = qb.pop_front();
        end
    end

    initial forever begin
        @(negedge clk);
        if (ready_a) begin
            chk("a_rgb", {vga_r_a, vga_g_a, vga_b_a}, {exp_a.r[7:0], exp_a.g[7:0], exp_a.b[7:0]});
            chk("a_ctl", {syncn_a, hs_a, vs_a, blank_a}, {1'b0, exp_a.hs, exp_a.vs, exp_a.bl});
            chk("a_fc", fc_a, fca);
            chk("a_clk", clk_a, clk);
        end
        if (ready_b) begin
            chk("b_rgb", {vga_r_b, vga_g_b, vga_b_b}, {exp_b.r[7:0], exp_b.g[7:0], exp_b.b[7:0]});
            chk("b_ctl", {syncn_b, hs_b, vs_b, blank_b}, {1'b0, exp_b.hs, exp_b.vs, exp_b.bl});
            chk("b_fc", fc_b, fcb);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic rand_colours();
        r_a = 4'($urandom); g_a = 4'($urandom); b_a = 4'($urandom);
        r_b = 5'($urandom); g_b = 5'($urandom); b_b = 5'($urandom);
    endtask

    task automatic vs_pulse();
        vs_act = 1'b1;
        @(negedge clk);
        vs_act = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic [23:0] seen [640];

    initial begin
        rst = 1'b1; vid = 1'b0; hs_act = 1'b0; vs_act = 1'b0; mode = 2'd0;
        r_a = '0; g_a = '0; b_a = '0; r_b = '0; g_b = '0; b_b = '0;
        solid_a = '0; solid_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_rgb_a", {vga_r_a, vga_g_a, vga_b_a}, 24'h0);
        chk("rst_sync_a", {hs_a, vs_a, blank_a}, 3'b110);
        chk("rst_sync_b", {hs_b, vs_b, blank_b}, 3'b000);
        chk("rst_fc_a", fc_a, 16'h0);
        rst = 1'b0;

        // Pass-through widening.
        r_a = 4'hA; g_a = 4'h5; b_a = 4'hF; r_b = 5'h15; g_b = 5'h01; b_b = 5'h1F; vid = 1'b1;
        repeat (2) @(negedge clk);
        chk("pass_rgb_a", {vga_r_a, vga_g_a, vga_b_a}, 24'hAA55FF);
        chk("pass_blank_a", blank_a, 1'b1);
        repeat (2) @(negedge clk);
        chk("pass_r_b", vga_r_b, 8'hAD);

        // Grayscale, then blanking at the same latency.
        vid = 1'b0; mode = 2'd1;
        vs_pulse();
        r_a = 4'd4; g_a = 4'd6; b_a = 4'd12; vid = 1'b1;
        repeat (2) @(negedge clk);
        chk("gray_rgb_a", {vga_r_a, vga_g_a, vga_b_a}, 24'h777777);
        chk("gray_fc_a", fc_a, 16'd1);
        chk("gray_fc_b", fc_b, 16'd1);
        vid = 1'b0;
        repeat (2) @(negedge clk);
        chk("blank_rgb_a", {vga_r_a, vga_g_a, vga_b_a, blank_a}, 25'h0);

        // One full bar line.
        mode = 2'd2;
        vs_pulse();
        for (int p = 0; p <= 640; p++) begin
            vid = (p < 640);
            rand_colours();
            @(negedge clk);
            if (p >= DA - 1 && p - (DA - 1) < 640) seen[p - (DA - 1)] = {vga_r_a, vga_g_a, vga_b_a};
        end
        vid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bar%0d_first", k), seen[k * 80], bar_rgb(k));
            chk($sformatf("bar%0d_last", k), seen[k * 80 + 79], bar_rgb(k));
        end
        repeat (20) @(negedge clk);
        vid = 1'b1;
        repeat (2) @(negedge clk);
        chk("bar_restart_a", {vga_r_a, vga_g_a, vga_b_a}, 24'hFFFFFF);
        vid = 1'b0;

        // Solid mode requested mid-frame only takes effect at the frame start.
        mode = 2'd0;
        vs_pulse();
        r_a = 4'h1; g_a = 4'h2; b_a = 4'h3; solid_a = 12'h3C5; vid = 1'b1;
        mode = 2'd3;
        repeat (3) @(negedge clk);
        chk("pre_solid_a", {vga_r_a, vga_g_a, vga_b_a}, 24'h112233);
        vs_act = 1'b1;
        @(negedge clk);
        chk("solid_fc_a", fc_a, 16'd4);
        @(negedge clk);
        chk("solid_rgb_a", {vga_r_a, vga_g_a, vga_b_a}, 24'h33CC55);
        vs_act = 1'b0; vid = 1'b0;
        repeat (4) @(negedge clk);

        // Asynchronous reset between clock edges.
        mode = 2'd0; vid = 1'b1; hs_act = 1'b1; rand_colours();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_rgb_a", {vga_r_a, vga_g_a, vga_b_a}, 24'h0);
        chk("arst_ctl_a", {hs_a, vs_a, blank_a}, 3'b110);
        chk("arst_ctl_b", {hs_b, vs_b, blank_b}, 3'b000);
        chk("arst_fc_a", fc_a, 16'h0);
        chk("arst_fc_b", fc_b, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; hs_act = 1'b0;

        // Randomised frames.
        for (int f = 0; f < 6; f++) begin
            solid_a = 12'($urandom);
            solid_b = 15'($urandom);
            for (int l = 0; l < 4; l++) begin
                int len;
                len = (l == 0) ? 640 : int'($urandom_range(1, 700));
                for (int p = 0; p < len; p++) begin
                    rand_colours();
                    vid = 1'b1;
                    if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
                    @(negedge clk);
                end
                vid = 1'b0;
                for (int p = 0; p < 12; p++) begin
                    hs_act = (p >= 3 && p < 8);
                    @(negedge clk);
                end
                hs_act = 1'b0;
            end
            mode = 2'($urandom_range(0, 3));
            vid = 1'($urandom_range(0, 1));
            rand_colours();
            vs_act = 1'b1;
            @(negedge clk);
            vid = 1'b0;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            vs_act = 1'b0;
            repeat (5) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
